// File: rtl/fletcher_axi_mem_pkg.sv
// Shared definitions for the Fletcher AXI4 memory responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   state_e                 : responder FSM states
//   rd_beat_t               : read beat {data, resp, last} for the default 512-bit bus.
//                             The top derives a width-matched copy of this struct.
package fletcher_axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int RD_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ       = 2'd1,
    ST_WRITE_DATA = 2'd2,
    ST_WRITE_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [RD_DATA_WIDTH-1:0] data;
    logic [1:0]               resp;
    logic                     last;
  } rd_beat_t;

endpackage

// File: rtl/fletcher_axi_mem_skid.sv
// Two-entry valid/ready buffer for read beats. Entry 0 is the output register.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, beat_i    : write a beat (never asserted while full without a pop)
//   pop_i             : consumer ready; pops when the head is valid
//   head_o, valid_o   : head entry and its valid flag
//   full_o, empty_o   : occupancy flags used to throttle read issue
module fletcher_axi_mem_skid
  import fletcher_axi_mem_pkg::*;
#(
  parameter type beat_t = rd_beat_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  beat_t beat_i,
  input  logic  pop_i,
  output beat_t head_o,
  output logic  valid_o,
  output logic  full_o,
  output logic  empty_o
);

  beat_t      ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    pop    = pop_i && (cnt_q != 2'd0);
    unique case ({push_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = beat_i;
        else               ent1_d = beat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = beat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = beat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fletcher_axi_mem_responder.sv
// AXI4 slave that serves the Fletcher accelerator's master port from an
// on-chip single-port array, one INCR burst at a time, no IDs.
//   bcd_clk, bcd_reset       : bus clock, synchronous active-high reset
//   s_axi_ar* / s_axi_r*     : read address and read data channels
//   s_axi_aw* / s_axi_w*     : write address and write data channels
//   s_axi_b*                 : write response channel
//   ar/awsize are ignored; every beat is full width.
//
// state         | meaning
// ST_IDLE       | arbitrate AR vs AW (round robin on contention)
// ST_READ       | issue array reads into the skid buffer, stream R beats
// ST_WRITE_DATA | accept W beats, byte-enable write into the array
// ST_WRITE_RESP | hold bvalid until bready
module fletcher_axi_mem_responder
  import fletcher_axi_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 512,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    bcd_clk,
  input  logic                    bcd_reset,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [LEN_WIDTH-1:0]    s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [LEN_WIDTH-1:0]    s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDE   = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } beat_t;

  state_e                state_q, state_d;
  logic                  prio_rd_q, prio_rd_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic                  below_q, below_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH:0]    beat_q, beat_d;
  logic                  werr_q, werr_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  pipe_v_q, pipe_oor_q, pipe_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle, grant_rd, grant_wr, ar_hs, aw_hs, r_hs, w_hs;
  logic [ADDR_WIDTH-1:0] req_addr, req_word, cur_word;
  logic                  req_below, cur_below, oor, issue_last, rd_issue, mem_we, werr_beat;
  logic [LEN_WIDTH:0]    cur_beat;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [WIDE-1:0]       idx;
  logic [2:0]            occ;
  beat_t                 push_beat, head;
  logic                  skid_full, skid_empty;
  logic                  unused_size;

  assign unused_size = ^{s_axi_arsize, s_axi_awsize};

  assign idle     = (state_q == ST_IDLE);
  assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || prio_rd_q);
  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !prio_rd_q);

  assign s_axi_arready = idle && grant_rd && !bcd_reset;
  assign s_axi_awready = idle && grant_wr && !bcd_reset;
  assign s_axi_wready  = (state_q == ST_WRITE_DATA);
  assign s_axi_bvalid  = (state_q == ST_WRITE_RESP);
  assign s_axi_bresp   = bresp_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign r_hs  = s_axi_rvalid && s_axi_rready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  // Beat 0 of a read is issued straight from araddr on the AR handshake so
  // the first beat appears two cycles later.
  assign req_addr  = grant_rd ? s_axi_araddr : s_axi_awaddr;
  assign req_below = (req_addr < BASE_ADDR);
  assign req_word  = (req_addr - BASE_ADDR) >> SHIFT;

  assign cur_word  = idle ? req_word  : start_q;
  assign cur_below = idle ? req_below : below_q;
  assign cur_beat  = idle ? '0        : beat_q;
  assign cur_len   = idle ? s_axi_arlen : len_q;

  // Widened by one bit so start + beat cannot wrap back into range.
  assign idx        = {1'b0, cur_word} + WIDE'(cur_beat);
  assign oor        = cur_below || (idx >= WIDE'(DEPTH));
  assign issue_last = (cur_beat == {1'b0, cur_len});

  // Beats in flight (skid + array stage) after this cycle's pop must stay
  // within the two skid slots.
  assign occ = (skid_full ? 3'd2 : (skid_empty ? 3'd0 : 3'd1))
             + {2'b00, pipe_v_q} - {2'b00, r_hs};

  assign rd_issue = ar_hs ||
                    ((state_q == ST_READ) && (beat_q <= {1'b0, len_q}) && (occ < 3'd2));

  assign werr_beat = oor || (beat_q > {1'b0, len_q}) ||
                     (s_axi_wlast && (beat_q < {1'b0, len_q}));
  assign mem_we    = (state_q == ST_WRITE_DATA) && w_hs &&
                     (beat_q <= {1'b0, len_q}) && !oor;

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    start_d   = start_q;
    below_d   = below_q;
    len_d     = len_q;
    beat_d    = beat_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          start_d   = req_word;
          below_d   = req_below;
          len_d     = s_axi_arlen;
          beat_d    = 1;
          prio_rd_d = 1'b0;
          state_d   = ST_READ;
        end else if (aw_hs) begin
          start_d   = req_word;
          below_d   = req_below;
          len_d     = s_axi_awlen;
          beat_d    = '0;
          werr_d    = 1'b0;
          prio_rd_d = 1'b1;
          state_d   = ST_WRITE_DATA;
        end
      end
      ST_READ: begin
        if (rd_issue) beat_d = beat_q + 1'b1;
        if (r_hs && s_axi_rlast) state_d = ST_IDLE;
      end
      ST_WRITE_DATA: begin
        if (w_hs) begin
          // Saturate so a runaway burst cannot wrap back into the legal range.
          if (beat_q != '1) beat_d = beat_q + 1'b1;
          werr_d = werr_q || werr_beat;
          if (s_axi_wlast) begin
            bresp_d = (werr_q || werr_beat) ? RESP_SLVERR : RESP_OKAY;
            state_d = ST_WRITE_RESP;
          end
        end
      end
      ST_WRITE_RESP: begin
        if (s_axi_bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bcd_clk) begin
    if (bcd_reset) begin
      state_q     <= ST_IDLE;
      prio_rd_q   <= 1'b1;
      start_q     <= '0;
      below_q     <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      werr_q      <= 1'b0;
      bresp_q     <= RESP_OKAY;
      pipe_v_q    <= 1'b0;
      pipe_oor_q  <= 1'b0;
      pipe_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      start_q   <= start_d;
      below_q   <= below_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
      pipe_v_q  <= rd_issue;
      if (rd_issue) begin
        pipe_oor_q  <= oor;
        pipe_last_q <= issue_last;
      end
    end
  end

  always_ff @(posedge bcd_clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[idx[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
    if (rd_issue) rd_data_q <= mem[idx[IDX_W-1:0]];
  end

  always_comb begin
    push_beat.data = pipe_oor_q ? '0 : rd_data_q;
    push_beat.resp = pipe_oor_q ? RESP_SLVERR : RESP_OKAY;
    push_beat.last = pipe_last_q;
  end

  fletcher_axi_mem_skid #(.beat_t(beat_t)) u_skid (
    .clk_i   (bcd_clk),
    .rst_i   (bcd_reset),
    .push_i  (pipe_v_q),
    .beat_i  (push_beat),
    .pop_i   (s_axi_rready),
    .head_o  (head),
    .valid_o (s_axi_rvalid),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  assign s_axi_rdata = head.data;
  assign s_axi_rresp = head.resp;
  assign s_axi_rlast = head.last;

endmodule

// File: tb/tb_fletcher_axi_mem_responder.sv
// Directed bench for fletcher_axi_mem_responder (default geometry:
// 512-bit beats, 1024 words, base address 0).
module tb_fletcher_axi_mem_responder;
  import fletcher_axi_mem_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int LW    = 8;
  localparam int DEPTH = 1024;
  localparam int SW    = DW / 8;
  localparam int CW    = DW + 8;

  logic          bcd_clk = 1'b0;
  logic          bcd_reset;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [LW-1:0] s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [LW-1:0] s_axi_awlen;
  logic [2:0]    s_axi_awsize;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [SW-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic [1:0]    s_axi_bresp;

  fletcher_axi_mem_responder dut (
    .bcd_clk(bcd_clk), .bcd_reset(bcd_reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp)
  );

  always #5 bcd_clk = ~bcd_clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] wr_data [32];
  logic [SW-1:0] wr_strb [32];
  logic [DW-1:0] rd_data [32];
  logic [1:0]    rd_resp [32];
  logic          rd_last [32];
  int            rd_cnt, rd_lat;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  function automatic logic rready_pat(input int k);
    if (k >= 3 && k < 13)  return 1'b0;
    if (k >= 25 && k < 40) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc();
    @(posedge bcd_clk);
    #1;
  endtask

  task automatic ar_phase(input int word, input int len);
    int g = 0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = AW'(word * SW);
    s_axi_arlen   = LW'(len);
    #1;
    while (!s_axi_arready && g < 100) begin cyc(); #1; g++; end
    chk("ar_accept", CW'(s_axi_arready), CW'(1));
    cyc();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic aw_phase(input int word, input int len);
    int g = 0;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = AW'(word * SW);
    s_axi_awlen   = LW'(len);
    #1;
    while (!s_axi_awready && g < 100) begin cyc(); #1; g++; end
    chk("aw_accept", CW'(s_axi_awready), CW'(1));
    cyc();
    s_axi_awvalid = 1'b0;
  endtask

  // Starts one cycle after the AR handshake; rd_lat = 2 means rvalid in T+2.
  task automatic read_data(input int len, input bit bp);
    int             guard = 0;
    bit             held  = 0;
    logic [DW+2:0]  held_v = '0;
    rd_cnt = 0;
    rd_lat = 0;
    while (rd_cnt <= len && guard < 2000) begin
      s_axi_rready = bp ? rready_pat(guard) : 1'b1;
      #1;
      if (s_axi_rvalid) begin
        if (rd_lat == 0) rd_lat = guard + 1;
        if (held) chk("stall_stable", CW'({s_axi_rdata, s_axi_rresp, s_axi_rlast}), CW'(held_v));
        if (s_axi_rready) begin
          if (rd_cnt < 32) begin
            rd_data[rd_cnt] = s_axi_rdata;
            rd_resp[rd_cnt] = s_axi_rresp;
            rd_last[rd_cnt] = s_axi_rlast;
          end
          rd_cnt++;
          held = 0;
        end else begin
          held   = 1;
          held_v = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
        end
      end
      cyc();
      guard++;
    end
    s_axi_rready = 1'b0;
    chk("rd_beats", CW'(rd_cnt), CW'(len + 1));
  endtask

  task automatic write_data(input int nbeats, output logic [1:0] bresp);
    int g = 0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wr_data[i];
      s_axi_wstrb  = wr_strb[i];
      s_axi_wlast  = (i == nbeats - 1);
      #1;
      while (!s_axi_wready && g < 100) begin cyc(); #1; g++; end
      cyc();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    s_axi_bready = 1'b1;
    #1;
    chk("bvalid_next", CW'(s_axi_bvalid), CW'(1));
    g = 0;
    while (!s_axi_bvalid && g < 100) begin cyc(); #1; g++; end
    bresp = s_axi_bresp;
    cyc();
    s_axi_bready = 1'b0;
  endtask

  task automatic do_write(input int word, input int len, input int nbeats, output logic [1:0] bresp);
    aw_phase(word, len);
    write_data(nbeats, bresp);
  endtask

  task automatic do_read(input int word, input int len, input bit bp);
    ar_phase(word, len);
    read_data(len, bp);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_data[i] = rep(32'(base + i));
      wr_strb[i] = '1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    br;
    int            win;
    logic [DW-1:0] exp_w5;
    logic [31:0]   exp_v [4];

    bcd_reset = 1'b1;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd6;
    s_axi_rready  = 0;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd6;
    s_axi_wvalid  = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready  = 0;
    repeat (3) cyc();
    chk("reset_ctrl", CW'({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid,
                           s_axi_rlast, s_axi_bvalid, s_axi_rresp, s_axi_bresp}), CW'(0));
    chk("reset_rdata", CW'(s_axi_rdata), CW'(0));
    bcd_reset = 1'b0;
    cyc();

    // Contention three times: read, write, read.
    for (int r = 0; r < 3; r++) begin
      s_axi_arvalid = 1; s_axi_araddr = AW'(10 * SW); s_axi_arlen = '0;
      s_axi_awvalid = 1; s_axi_awaddr = AW'(11 * SW); s_axi_awlen = '0;
      #1;
      win = s_axi_arready ? 1 : (s_axi_awready ? 0 : 2);
      chk($sformatf("arb%0d", r), CW'(win), CW'((r == 1) ? 0 : 1));
      cyc();
      s_axi_arvalid = 0;
      s_axi_awvalid = 0;
      if (win == 1) read_data(0, 0);
      else if (win == 0) begin fill(1, r); write_data(1, br); end
    end

    // Write then read, 4 beats from address 0.
    fill(4, 0);
    do_write(0, 3, 4, br);
    chk("wr_bresp", CW'(br), CW'(RESP_OKAY));
    do_read(0, 3, 0);
    chk("rd_lat", CW'(rd_lat), CW'(2));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_rd_data%0d", i), CW'(rd_data[i]), CW'(rep(32'(i))));
      chk($sformatf("wr_rd_resp%0d", i), CW'(rd_resp[i]), CW'(RESP_OKAY));
      chk($sformatf("wr_rd_last%0d", i), CW'(rd_last[i]), CW'(i == 3));
    end

    // Byte strobes on word 5.
    wr_data[0] = '1; wr_strb[0] = '1;
    do_write(5, 0, 1, br);
    wr_data[0] = '0; wr_strb[0] = SW'(1);
    do_write(5, 0, 1, br);
    do_read(5, 0, 0);
    exp_w5 = {{(SW-1){8'hFF}}, 8'h00};
    chk("strobe_data", CW'(rd_data[0]), CW'(exp_w5));

    // Range crossing at DEPTH-2.
    fill(2, 32'hA0);
    do_write(DEPTH - 2, 1, 2, br);
    do_read(DEPTH - 2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("range_data%0d", i), CW'(rd_data[i]), CW'((i < 2) ? rep(32'(32'hA0 + i)) : '0));
      chk($sformatf("range_resp%0d", i), CW'(rd_resp[i]), CW'((i < 2) ? RESP_OKAY : RESP_SLVERR));
      chk($sformatf("range_last%0d", i), CW'(rd_last[i]), CW'(i == 3));
    end

    // 16-beat read with random and long rready stalls.
    fill(16, 32'h100);
    do_write(100, 15, 16, br);
    do_read(100, 15, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_data%0d", i), CW'(rd_data[i]), CW'(rep(32'(32'h100 + i))));
      chk($sformatf("bp_last%0d", i), CW'(rd_last[i]), CW'(i == 15));
    end

    // Early wlast: len 3 but only 2 beats.
    fill(4, 32'h50);
    do_write(200, 3, 4, br);
    fill(2, 32'h60);
    do_write(200, 3, 2, br);
    chk("early_bresp", CW'(br), CW'(RESP_SLVERR));
    do_read(200, 3, 0);
    exp_v[0] = 32'h60; exp_v[1] = 32'h61; exp_v[2] = 32'h52; exp_v[3] = 32'h53;
    for (int i = 0; i < 4; i++)
      chk($sformatf("early_data%0d", i), CW'(rd_data[i]), CW'(rep(exp_v[i])));

    // Excess beat: len 0 with 2 beats; the second must not reach word 211.
    fill(1, 32'h33);
    do_write(211, 0, 1, br);
    fill(2, 32'h70);
    do_write(210, 0, 2, br);
    chk("excess_bresp", CW'(br), CW'(RESP_SLVERR));
    do_read(210, 1, 0);
    chk("excess_w0", CW'(rd_data[0]), CW'(rep(32'h70)));
    chk("excess_w1", CW'(rd_data[1]), CW'(rep(32'h33)));

    // Reset in the middle of a stalled read.
    ar_phase(100, 7);
    s_axi_rready = 1'b0;
    repeat (4) cyc();
    chk("mid_rvalid", CW'(s_axi_rvalid), CW'(1));
    bcd_reset = 1'b1;
    cyc();
    chk("mid_rst_ctrl", CW'({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid,
                             s_axi_rlast, s_axi_bvalid, s_axi_rresp, s_axi_bresp}), CW'(0));
    chk("mid_rst_rdata", CW'(s_axi_rdata), CW'(0));
    bcd_reset = 1'b0;
    cyc();
    do_read(0, 3, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("post_rst_data%0d", i), CW'(rd_data[i]), CW'(rep(32'(i))));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fletcher_axi_mem_responder.md
# fletcher_axi_mem_responder

AXI4 memory responder that answers the Fletcher accelerator's AXI4 master port (read and write bursts) from an on-chip memory array. It replaces the shell DDR path in simulation and in BAR-only builds, sitting directly on the accelerator's `m_axi_*` port in the bus clock domain. It serves one burst at a time from a single-port array and arbitrates reads against writes.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: byte address width.
- `DATA_WIDTH`, 512: beat width; power of two, at least 32.
- `LEN_WIDTH`, 8: `axlen` width.
- `DEPTH`, 1024: memory words of `DATA_WIDTH`; power of two.
- `BASE_ADDR`, 0: byte address of word 0.

Ports (one clock; reset is synchronous and active-high):
- `bcd_clk` in 1: bus clock.
- `bcd_reset` in 1: synchronous reset, active-high.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address handshake.
- `s_axi_araddr` in ADDR_WIDTH: burst start byte address.
- `s_axi_arlen` in LEN_WIDTH: beats minus one.
- `s_axi_arsize` in 3: ignored; every beat is treated as full width.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data handshake.
- `s_axi_rdata` out DATA_WIDTH.
- `s_axi_rresp` out 2.
- `s_axi_rlast` out 1.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1, `s_axi_awaddr` in ADDR_WIDTH, `s_axi_awlen` in LEN_WIDTH, `s_axi_awsize` in 3 (ignored): write address.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data handshake.
- `s_axi_wdata` in DATA_WIDTH, `s_axi_wstrb` in DATA_WIDTH/8, `s_axi_wlast` in 1.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1, `s_axi_bresp` out 2: write response.

## Operation
- The FSM has states IDLE, READ, WRITE_DATA and WRITE_RESP. Bursts are INCR only; there are no IDs.
- IDLE:
  - `arready`/`awready` are high only in IDLE, and only for the channel selected by the arbiter.
  - If only one of `arvalid`/`awvalid` is high, that channel wins.
  - If both are high, round-robin: the winner is the channel that did not win last time. After reset, read wins first.
  - Accepting AR latches the start word and `arlen`, then moves to READ. Accepting AW does the same with `awlen`, then moves to WRITE_DATA.
- Word index per beat = ((addr − BASE_ADDR) >> log2(DATA_WIDTH/8)) + beat number. The low address bits are dropped, so unaligned starts are aligned down.
- A beat is out of range if its index ≥ DEPTH or addr < BASE_ADDR. Out-of-range beats:
  - Reads return `rdata`=0 and `rresp`=2'b10 (SLVERR).
  - Writes are suppressed; the burst's `bresp` becomes SLVERR.
  - Indices never wrap.
- READ:
  - Issues one array read per cycle while the skid buffer has a free slot, tagging each beat with its resp and last bit.
  - `rlast` is high on beat `arlen`.
  - Returns to IDLE the cycle after the last beat handshakes.
- WRITE_DATA:
  - `wready` is high. Each accepted beat writes the bytes enabled by `wstrb`.
  - On `wlast`, moves to WRITE_RESP.
  - If `wlast` arrives before beat `awlen`, or beats exceed `awlen`+1, the excess beats are not written and `bresp` is SLVERR.
- WRITE_RESP: `bvalid` is high until `bready`, then the FSM returns to IDLE.
- Memory contents are not reset.

## Timing
- Reset values: all readies and valids 0, `rdata` 0, `rresp` 0, `rlast` 0, `bresp` 0, arbiter pointer = read.
- Reset mid-burst aborts the burst immediately. No response is issued for it.
- Read:
  - AR handshake in cycle T; first `rvalid` in T+2 (registered array read plus output register).
  - Sustains 1 beat/cycle while `rready` is high.
  - While `rvalid` is high and `rready` is low, `rdata`/`rresp`/`rlast` hold stable.
  - No beat is lost or duplicated; the skid buffer holds 2 entries.
- Write:
  - AW handshake in T; `wready` high from T+1. One beat is written per cycle when `wvalid` is high.
  - `bvalid` rises the cycle after the `wlast` handshake.
- Turnaround: a new AR/AW can be accepted the cycle after returning to IDLE, so the minimum gap between bursts is 1 cycle.
- A write followed by a read to the same word returns the new data.

## Structure
- A shared package holds:
  - `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - The FSM state enum.
  - A read-beat struct {data, resp, last}.
- Sub-module `fletcher_axi_mem_skid`: a 2-entry valid/ready buffer of read-beat structs, with full/empty flags driving read issue.
- The memory array is inferred inside the top with a byte-enable write and a registered read.

## Test plan
- Write then read: AW addr 0x0, len 3, `wdata` = beat index replicated, `wstrb` all ones, then AR addr 0x0, len 3.
  - Required: `bresp` OKAY; 4 `rdata` beats equal to 0..3, `rresp` OKAY, `rlast` only on beat 3, first `rvalid` 2 cycles after AR.
- Byte strobes: write 0xFF.. to word 5, then write `wstrb`=0x1 with data 0x00 to word 5, then read word 5.
  - Required: byte 0 reads 0x00 and all other bytes read 0xFF.
- Range crossing: AR at word DEPTH−2, len 3.
  - Required: beats 0–1 OKAY with data; beats 2–3 `rdata`=0 with SLVERR; `rlast` on beat 3.
- Backpressure: 16-beat read with `rready` toggled at random, including long low stretches.
  - Required: data is in order and complete, and `rdata` is stable while stalled.
- Arbitration: `arvalid` and `awvalid` asserted together three times in succession.
  - Required: the bursts are served read, write, read.
- Protocol error and reset: AW len 3 with `wlast` on beat 1.
  - Required: 2 beats written, `bresp` SLVERR.
  - Then assert `bcd_reset` mid-read: all outputs return to their reset values the next cycle, and a fresh read succeeds afterwards.
